// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: shift modes and FSM states.
package shift_seq_pkg;

  localparam logic [1:0] MODE_SHL  = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Right-moving modes (SHR, ROTR) shift bit 0 out first.
  function automatic logic mode_is_right(input logic [1:0] m);
    return m[0];
  endfunction

endpackage

// File: rtl/shift_seq_core.sv
// WIDTH-bit pattern register with load / one-step shift / hold.
// fill is only used by the zero-fill modes; rotates recirculate the outgoing bit.
module shift_seq_core
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] seq
);

  logic [WIDTH-1:0] shifted;

  // Next value after one shift step in the selected mode.
  always_comb begin
    shifted = seq;
    case (mode)
      MODE_SHL:  shifted = {seq[WIDTH-2:0], fill};
      MODE_SHR:  shifted = {fill, seq[WIDTH-1:1]};
      MODE_ROTL: shifted = {seq[WIDTH-2:0], seq[WIDTH-1]};
      MODE_ROTR: shifted = {seq[0], seq[WIDTH-1:1]};
    endcase
  end

  // Pattern register; the controller never requests load and shift together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seq <= RESET_VAL;
    else if (load_en)
      seq <= load_data;
    else if (shift_en)
      seq <= shifted;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Loadable shift/rotate register with a run controller.
// Optional feature: define SHIFT_SEQ_SERIAL_IN_EN to add a serial_in port that
// feeds the fill bit of the zero-fill modes.
// The register output is named seq because "sequence" is a reserved word.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | after reset; accepts load and start
//  ST_RUN  | one shift per unpaused clock until NUM_SHIFTS are done
//  ST_DONE | run complete; holds result, accepts load and start again
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter int               NUM_SHIFTS = WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int               CNT_W      = $clog2(NUM_SHIFTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       mode,
`ifdef SHIFT_SEQ_SERIAL_IN_EN
  input  logic             serial_in,
`endif
  output logic [WIDTH-1:0] seq,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [1:0] state;
  logic [1:0] mode_q;
  logic       accepting;
  logic       do_load;
  logic       do_start;
  logic       do_shift;
  logic       last_shift;
  logic       fill;

  // Any non-RUN state (including an unreachable encoding) behaves like IDLE.
  assign accepting  = (state != ST_RUN);
  assign do_load    = accepting && load;
  assign do_start   = accepting && start;
  assign do_shift   = !accepting && !pause;
  assign last_shift = do_shift && (shift_cnt == CNT_W'(NUM_SHIFTS - 1));

`ifdef SHIFT_SEQ_SERIAL_IN_EN
  assign fill = serial_in;
`else
  assign fill = 1'b0;
`endif

  assign serial_out = mode_is_right(mode_q) ? seq[0] : seq[WIDTH-1];

  shift_seq_core #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_en   (do_load),
    .load_data (load_data),
    .shift_en  (do_shift),
    .mode      (mode_q),
    .fill      (fill),
    .seq       (seq)
  );

  // Run controller: start from IDLE/DONE, finish on the final unpaused shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_SHL;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (last_shift) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state  <= ST_RUN;
            mode_q <= mode;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Shifts completed in the current or most recent run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shift_cnt <= '0;
    else if (do_start)
      shift_cnt <= '0;
    else if (do_shift)
      shift_cnt <= shift_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (WIDTH=10, NUM_SHIFTS=10).
// Stimulus pushes expected snapshots tagged with a cycle number; the monitor
// compares them on the falling edge of that cycle.
module tb_shift_sequencer;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [1:0]   mode = 2'b00;
`ifdef SHIFT_SEQ_SERIAL_IN_EN
  logic         serial_in = 1'b0;
`endif
  logic [W-1:0] seq;
  logic         serial_out;
  logic         busy;
  logic         done;
  logic [3:0]   shift_cnt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int           cyc;
    string        name;
    logic [W-1:0] seq;
    logic [3:0]   cnt;
    logic         busy;
    logic         done;
    logic         ser;
  } exp_t;

  exp_t q[$];
  exp_t e;

  shift_sequencer #(.WIDTH(W), .NUM_SHIFTS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .start      (start),
    .pause      (pause),
    .mode       (mode),
`ifdef SHIFT_SEQ_SERIAL_IN_EN
    .serial_in  (serial_in),
`endif
    .seq        (seq),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .shift_cnt  (shift_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: sample slot missed, due cycle %0d now %0d", e.name, e.cyc, cyc);
      end else if (seq !== e.seq || shift_cnt !== e.cnt || busy !== e.busy ||
                   done !== e.done || serial_out !== e.ser) begin
        failures++;
        $display("FAIL %s: got seq=%b cnt=%0d busy=%b done=%b ser=%b, want seq=%b cnt=%0d busy=%b done=%b ser=%b",
                 e.name, seq, shift_cnt, busy, done, serial_out,
                 e.seq, e.cnt, e.busy, e.done, e.ser);
      end
    end
  end

  task automatic exp_push(input int d, input string nm, input logic [W-1:0] s,
                          input int c, input logic b, input logic dn, input logic sr);
    exp_t x;
    x.cyc  = cyc + d;
    x.name = nm;
    x.seq  = s;
    x.cnt  = 4'(c);
    x.busy = b;
    x.done = dn;
    x.ser  = sr;
    q.push_back(x);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    exp_push(0, "reset", 10'h000, 0, 0, 0, 0);
    step();
    rst = 0;
    step();

    // 1: shift-left zero fill
    load = 1; load_data = 10'b1011001110; mode = 2'b00;
    step();
    load = 0; start = 1;
    exp_push(1,  "t1_start",  10'b1011001110, 0,  1, 0, 1);
    exp_push(2,  "t1_shift1", 10'b0110011100, 1,  1, 0, 0);
    exp_push(11, "t1_done",   10'h000,        10, 0, 1, 0);
    exp_push(12, "t1_hold",   10'h000,        10, 0, 1, 0);
    step(); start = 0;
    step(11);

    // 2: rotate left with a 3-cycle pause after the first shift
    load = 1; load_data = 10'h201; mode = 2'b10;
    step();
    load = 0; start = 1;
    exp_push(1,  "t2_start",  10'h201, 0,  1, 0, 1);
    exp_push(2,  "t2_shift1", 10'h003, 1,  1, 0, 0);
    exp_push(3,  "t2_pause1", 10'h003, 1,  1, 0, 0);
    exp_push(4,  "t2_pause2", 10'h003, 1,  1, 0, 0);
    exp_push(5,  "t2_pause3", 10'h003, 1,  1, 0, 0);
    exp_push(6,  "t2_shift2", 10'h006, 2,  1, 0, 0);
    exp_push(13, "t2_shift9", 10'h300, 9,  1, 0, 1);
    exp_push(14, "t2_done",   10'h201, 10, 0, 1, 1);
    step(); start = 0;
    step(); pause = 1;
    step(3); pause = 0;
    step(9);

    // 3: rotate right, serial_out sequence 1,0,1,0
    load = 1; load_data = 10'b0000000101; mode = 2'b11;
    step();
    load = 0; start = 1;
    exp_push(1,  "t3_ser0", 10'b0000000101, 0,  1, 0, 1);
    exp_push(2,  "t3_ser1", 10'b1000000010, 1,  1, 0, 0);
    exp_push(3,  "t3_ser2", 10'b0100000001, 2,  1, 0, 1);
    exp_push(4,  "t3_ser3", 10'b1010000000, 3,  1, 0, 0);
    exp_push(11, "t3_done", 10'b0000000101, 10, 0, 1, 1);
    step(); start = 0;
    step(10);

    // 4: restart from DONE, then async reset after 4 shifts
    mode = 2'b00; start = 1;
    exp_push(1, "t4_start", 10'h005, 0, 1, 0, 0);
    step(); start = 0;
    step(4);
    #2 rst = 1;
    exp_push(0, "t4_rst_async", 10'h000, 0, 0, 0, 0);
    step(2);
    rst = 0;
    exp_push(1, "t4_no_done_a", 10'h000, 0, 0, 0, 0);
    exp_push(3, "t4_no_done_b", 10'h000, 0, 0, 0, 0);
    step(3);

    // 5: load+start together; load/start/mode during RUN ignored
    load = 1; load_data = 10'h3FF; mode = 2'b01; start = 1;
    exp_push(1,  "t5_start",  10'h3FF, 0,  1, 0, 1);
    exp_push(2,  "t5_shift1", 10'h1FF, 1,  1, 0, 1);
    exp_push(11, "t5_done",   10'h000, 10, 0, 1, 0);
    exp_push(12, "t5_hold",   10'h000, 10, 0, 1, 0);
    step();
    load_data = 10'h000; mode = 2'b10;
    step(10);
    load = 0; start = 0;
    step();

`ifdef SHIFT_SEQ_SERIAL_IN_EN
    // 6: serial fill in shl, ignored in rotl
    load = 1; load_data = 10'h000; mode = 2'b00; serial_in = 1; start = 1;
    exp_push(1,  "t6_start",  10'h000, 0,  1, 0, 0);
    exp_push(2,  "t6_shift1", 10'h001, 1,  1, 0, 0);
    exp_push(3,  "t6_shift2", 10'h003, 2,  1, 0, 0);
    exp_push(4,  "t6_shift3", 10'h007, 3,  1, 0, 0);
    exp_push(11, "t6_done",   10'h3FF, 10, 0, 1, 1);
    step(); load = 0; start = 0;
    step(10);
    load = 1; load_data = 10'h000; mode = 2'b10; start = 1;
    exp_push(2,  "t6_rot1", 10'h000, 1,  1, 0, 0);
    exp_push(4,  "t6_rot3", 10'h000, 3,  1, 0, 0);
    exp_push(11, "t6_rot_done", 10'h000, 10, 0, 1, 0);
    step(); load = 0; start = 0;
    step(10);
    serial_in = 0;
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never sampled, due cycle %0d now %0d", e.name, e.cyc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
